// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding one UART transmitter from N_REQ requesters
module uart_tx_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 9
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_lock,
  output logic [N_REQ-1:0]           ack,
  output logic [N_REQ-1:0]           done,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       tx_send,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_ready
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  winner;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        wd_q, wd_d;
  logic              hi_q, hi_d;
  logic              found;
  logic              complete;

  // First set request at or after last_grant+1, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req[(int'(last_q) + k) % N_REQ]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(last_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    data_d   = data_q;
    wd_d     = wd_q;
    hi_d     = hi_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_ready && found) begin
          state_d = ISSUE;
          grant_d = winner;
          last_d  = winner;
          data_d  = req_data[int'(winner)*DATA_W +: DATA_W];
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        wd_d    = '0;
      end
      WAIT_BUSY: begin
        if (!tx_ready) begin
          state_d = WAIT_DONE;
          hi_d    = 1'b0;
        end else if (wd_q == 2'd3) begin
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 2'd1;
        end
      end
      WAIT_DONE: begin
        // Completion needs two consecutive high samples; a lone high is discarded.
        if (tx_ready && hi_q) begin
          complete = 1'b1;
          if (req_lock[grant_q] && req[grant_q]) begin
            state_d = ISSUE;
            data_d  = req_data[int'(grant_q)*DATA_W +: DATA_W];
          end else begin
            state_d = IDLE;
          end
        end else begin
          hi_d = tx_ready;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_IDX;
      data_q  <= '0;
      wd_q    <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
      hi_q    <= hi_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign tx_send  = (state_q == ISSUE);
  assign ack      = tx_send ? (N_REQ'(1) << grant_q) : '0;
  assign done     = complete ? (N_REQ'(1) << grant_q) : '0;
  assign grant_id = grant_q;
  assign tx_data  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 9;

  logic           clock = 1'b0;
  logic           reset_n = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_lock = '0;
  logic [N-1:0]   ack, done;
  logic [1:0]     grant_id;
  logic           busy, tx_send;
  logic [W-1:0]   tx_data;
  logic           tx_ready = 1'b1;

  always #5 clock = ~clock;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data),
    .req_lock(req_lock), .ack(ack), .done(done), .grant_id(grant_id),
    .busy(busy), .tx_send(tx_send), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int words_left[N];
  int seq[N];
  logic [N-1:0] lock_cfg = '0;
  int uart_mode = 0;
  bit rdy_q[$];
  int ack_log[$], ack_cyc[$], grant_log[$], done_log[$], done_cyc[$];

  // Line-level model: free line, awaiting the transmitter to go busy, or word on the line.
  bit m_free, m_wait, m_intx, m_hi, m_ackp;
  int m_wcnt, m_owner, m_grant, m_last, m_ackwho;
  logic [W-1:0] m_data, m_ackdata;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] word_of(int i);
    return W'(i * 64 + seq[i]);
  endfunction

  function automatic int rr(logic [N-1:0] r, int last);
    for (int k = 1; k <= N; k++) begin
      int idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_free = 1; m_wait = 0; m_intx = 0; m_hi = 0; m_ackp = 0;
    m_wcnt = 0; m_owner = 0; m_grant = 0; m_last = N - 1; m_ackwho = 0;
    m_data = '0; m_ackdata = '0;
  endtask

  task automatic clear_logs();
    ack_log.delete(); ack_cyc.delete(); grant_log.delete();
    done_log.delete(); done_cyc.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = (words_left[i] > 0);
      req_data[i*W +: W] = word_of(i);
    end
    req_lock = lock_cfg;
    tx_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
  endtask

  task automatic compare_and_model();
    logic [N-1:0] exp_ack, exp_done;
    exp_ack = m_ackp ? (N'(1) << m_ackwho) : '0;
    if (m_ackp) begin
      m_data  = m_ackdata;
      m_grant = m_ackwho;
    end
    exp_done = (m_intx && tx_ready && m_hi) ? (N'(1) << m_owner) : '0;
    chk("ack", ack, exp_ack);
    chk("done", done, exp_done);
    chk("tx_send", tx_send, m_ackp);
    chk("busy", busy, !m_free);
    chk("grant_id", grant_id, m_grant);
    chk("tx_data", tx_data, m_data);
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin ack_log.push_back(i); ack_cyc.push_back(cyc); grant_log.push_back(grant_id); end
      if (done[i]) begin done_log.push_back(i); done_cyc.push_back(cyc); end
    end
    if (m_ackp) begin
      m_ackp = 0; m_owner = m_ackwho; m_wait = 1; m_wcnt = 0;
    end else if (m_wait) begin
      if (!tx_ready) begin
        m_wait = 0; m_intx = 1; m_hi = 0;
      end else begin
        m_wcnt++;
        if (m_wcnt == 4) begin m_wait = 0; m_free = 1; end
      end
    end else if (m_intx) begin
      if (tx_ready && m_hi) begin
        m_intx = 0;
        if (req_lock[m_owner] && req[m_owner]) begin
          m_ackp = 1; m_ackwho = m_owner; m_ackdata = req_data[m_owner*W +: W];
        end else begin
          m_free = 1;
        end
      end else begin
        m_hi = tx_ready;
      end
    end else if (m_free && tx_ready && (|req)) begin
      m_ackwho = rr(req, m_last); m_last = m_ackwho;
      m_ackp = 1; m_free = 0; m_ackdata = req_data[m_ackwho*W +: W];
    end
    for (int i = 0; i < N; i++)
      if (ack[i] && words_left[i] > 0) begin words_left[i]--; seq[i]++; end
    if (tx_send) begin
      rdy_q.delete();
      if (uart_mode == 0) rdy_q = '{0, 0, 0, 1, 1};
      else if (uart_mode == 2) rdy_q = '{0, 0, 1, 0, 0, 1, 1};
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
    drive();
    cyc++;
    @(negedge clock);
    compare_and_model();
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    req = '0; req_lock = '0; tx_ready = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_tx_data", tx_data, 0);
    model_reset();
    rdy_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  function automatic bit quiet();
    for (int i = 0; i < N; i++) if (words_left[i] > 0) return 0;
    return m_free && !m_ackp;
  endfunction

  task automatic run_quiet(int budget);
    int n = 0;
    do begin step(); n++; end while (!quiet() && n < budget);
    chk("quiet_within_budget", (n < budget), 1);
    step(); step();
  endtask

  task automatic start(int mode);
    uart_mode = mode;
    lock_cfg = '0;
    for (int i = 0; i < N; i++) begin words_left[i] = 0; seq[i] = 0; end
    do_reset();
    clear_logs();
  endtask

  initial begin
    int exp_b[8];
    int n;
    int a;
    exp_b = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Two requesters after reset: 0 first, 2 after 0's word completes.
    start(0);
    words_left[0] = 1; words_left[2] = 1;
    run_quiet(60);
    chk("a_acks", ack_log.size(), 2);
    chk("a_ack0", ack_log.size() > 0 ? ack_log[0] : -1, 0);
    chk("a_ack1", ack_log.size() > 1 ? ack_log[1] : -1, 2);
    chk("a_grant0", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    chk("a_grant1", grant_log.size() > 1 ? grant_log[1] : -1, 2);
    chk("a_dones", done_log.size(), 2);
    chk("a_gap", ack_cyc.size() > 1 ? ack_cyc[1] - ack_cyc[0] : -1, 7);
    chk("a_done_before_ack", done_cyc.size() > 0 && ack_cyc.size() > 1 ? int'(done_cyc[0] < ack_cyc[1]) : 0, 1);

    // All four requesting, two words each: strict rotation.
    start(0);
    for (int i = 0; i < N; i++) words_left[i] = 2;
    run_quiet(200);
    chk("b_acks", ack_log.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("b_order%0d", i), ack_log.size() > i ? ack_log[i] : -1, exp_b[i]);
    for (int i = 1; i < 8; i++)
      chk($sformatf("b_norepeat%0d", i), ack_log.size() > i ? int'(ack_log[i] != ack_log[i-1]) : 0, 1);

    // Burst lock: requester 1 keeps the grant for three words, then 0.
    start(0);
    words_left[0] = 1;
    run_quiet(60);
    clear_logs();
    lock_cfg = 4'b0010;
    words_left[0] = 1; words_left[1] = 3;
    run_quiet(120);
    chk("c_acks", ack_log.size(), 4);
    chk("c_ack0", ack_log.size() > 0 ? ack_log[0] : -1, 1);
    chk("c_ack1", ack_log.size() > 1 ? ack_log[1] : -1, 1);
    chk("c_ack2", ack_log.size() > 2 ? ack_log[2] : -1, 1);
    chk("c_ack3", ack_log.size() > 3 ? ack_log[3] : -1, 0);
    chk("c_lock_gap", ack_cyc.size() > 1 ? ack_cyc[1] - ack_cyc[0] : -1, 6);
    chk("c_rearb_gap", ack_cyc.size() > 3 ? ack_cyc[3] - ack_cyc[2] : -1, 7);

    // Transmitter never goes busy: watchdog returns to idle, no done.
    start(1);
    words_left[2] = 1;
    n = 0;
    do begin step(); n++; end while (ack_log.size() == 0 && n < 10);
    chk("d_ack_seen", ack_log.size(), 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("d_busy%0d", i), busy, 1);
    end
    step();
    chk("d_idle", busy, 0);
    run_quiet(20);
    chk("d_no_done", done_log.size(), 0);

    // One-cycle tx_ready glitch mid-word is ignored.
    start(2);
    words_left[1] = 1;
    run_quiet(60);
    chk("e_dones", done_log.size(), 1);
    chk("e_done_lat", (done_cyc.size() > 0 && ack_cyc.size() > 0) ? done_cyc[0] - ack_cyc[0] : -1, 7);

    // Reset during a word: abort, then lowest set index wins.
    start(0);
    words_left[2] = 2; words_left[3] = 1;
    n = 0;
    do begin step(); n++; end while (!m_intx && n < 30);
    chk("f_in_word", m_intx, 1);
    chk("f_ack_before", ack_log.size() > 0 ? ack_log[0] : -1, 2);
    a = done_log.size();
    do_reset();
    chk("f_no_done", a, 0);
    clear_logs();
    run_quiet(80);
    chk("f_first_after_rst", ack_log.size() > 0 ? ack_log[0] : -1, 2);
    chk("f_second_after_rst", ack_log.size() > 1 ? ack_log[1] : -1, 3);
    chk("f_dones", done_log.size(), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "bench timeout");
  end
endmodule
